// File: rtl/bp_cce_pending_ctr_if.sv
// bp_cce_pending_ctr_if: pending-write, read and status bundle for the CCE pending counters.
// The master drives writes and reads. The slave returns read data, busy and error status.
interface bp_cce_pending_ctr_if #(
    parameter int paddr_width_p = 40
);
    logic                     w_v_i;
    logic [paddr_width_p-1:0] w_addr_i;
    logic                     w_addr_bypass_i;
    logic                     pending_i;
    logic                     r_v_i;
    logic [paddr_width_p-1:0] r_addr_i;
    logic                     r_addr_bypass_i;
    logic                     pending_v_o;
    logic                     pending_o;
    logic                     busy_o;
    logic                     err_o;

    modport master (
        output w_v_i, w_addr_i, w_addr_bypass_i, pending_i,
        output r_v_i, r_addr_i, r_addr_bypass_i,
        input  pending_v_o, pending_o, busy_o, err_o
    );

    modport slave (
        input  w_v_i, w_addr_i, w_addr_bypass_i, pending_i,
        input  r_v_i, r_addr_i, r_addr_bypass_i,
        output pending_v_o, pending_o, busy_o, err_o
    );
endinterface

// File: rtl/bp_cce_pending_ctr.sv
// bp_cce_pending_ctr: per-block saturating pending counters with self-clear after reset.
// Macro BP_CCE_PENDING_CTR_ERR_EN enables sticky err_o and the overflow/underflow checks.
module bp_cce_pending_ctr #(
    parameter int paddr_width_p    = 40,
    parameter int num_entries_p    = 256,
    parameter int cnt_width_p      = 4,
    parameter int lg_block_bytes_p = 6
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    bp_cce_pending_ctr_if.slave bus
);
    localparam int lg_entries_lp = $clog2(num_entries_p);

    typedef logic [lg_entries_lp-1:0] idx_t;
    typedef logic [cnt_width_p-1:0]   cnt_t;

    localparam idx_t LAST_IDX = idx_t'(num_entries_p - 1);
    localparam cnt_t CNT_MAX  = '1;

    typedef enum logic [1:0] {
        e_reset,
        e_clear,
        e_ready
    } state_e;

    state_e r_state;
    state_e w_state_nxt;
    idx_t   r_clr_idx;
    idx_t   w_clr_idx_nxt;
    cnt_t   r_mem [num_entries_p];

    logic [paddr_width_p-1:0] w_w_addr;
    logic [paddr_width_p-1:0] w_r_addr;

    logic w_busy;
    logic w_w_fire;
    logic w_r_fire;
    idx_t w_w_idx;
    idx_t w_r_idx;
    cnt_t w_w_cur;
    cnt_t w_w_nxt;
    cnt_t w_r_cnt;
    logic w_ovf;
    logic w_unf;
    logic w_err;
    logic r_pending_v;
    logic r_pending;
    logic w_unused;

    assign w_w_addr = bus.w_addr_i;
    assign w_r_addr = bus.r_addr_i;

    assign w_busy   = (r_state != e_ready);
    assign w_w_fire = bus.w_v_i & ~w_busy;
    assign w_r_fire = bus.r_v_i & ~w_busy;

    assign w_w_idx = bus.w_addr_bypass_i
                   ? w_w_addr[lg_entries_lp-1:0]
                   : w_w_addr[lg_block_bytes_p +: lg_entries_lp];
    assign w_r_idx = bus.r_addr_bypass_i
                   ? w_r_addr[lg_entries_lp-1:0]
                   : w_r_addr[lg_block_bytes_p +: lg_entries_lp];

    // State and clear-index registers; both restart on any reset.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state   <= e_reset;
            r_clr_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
        end
    end

    // Sequence reset -> clear every entry -> ready (terminal).
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        unique case (r_state)
            e_reset: begin
                w_state_nxt = e_clear;
            end
            e_clear: begin
                w_clr_idx_nxt = r_clr_idx + idx_t'(1);
                if (r_clr_idx == LAST_IDX) begin
                    w_state_nxt = e_ready;
                end
            end
            default: begin
                w_state_nxt = e_ready;
            end
        endcase
    end

    // Saturating next count for the write index, flagging over/underflow.
    always_comb begin
        w_w_cur = r_mem[w_w_idx];
        w_w_nxt = w_w_cur;
        w_ovf   = 1'b0;
        w_unf   = 1'b0;
        if (bus.pending_i) begin
            if (w_w_cur == CNT_MAX) begin
                w_ovf = 1'b1;
            end else begin
                w_w_nxt = w_w_cur + cnt_t'(1);
            end
        end else begin
            if (w_w_cur == '0) begin
                w_unf = 1'b1;
            end else begin
                w_w_nxt = w_w_cur - cnt_t'(1);
            end
        end
    end

    // A same-index write in this cycle is forwarded to the read.
    assign w_r_cnt = (w_w_fire && (w_w_idx == w_r_idx)) ? w_w_nxt : r_mem[w_r_idx];

    // Counter storage: zeroed by the clear walk, updated by accepted writes.
    always_ff @(posedge clk_i) begin
        if (r_state == e_clear) begin
            r_mem[r_clr_idx] <= '0;
        end else if (w_w_fire) begin
            r_mem[w_w_idx] <= w_w_nxt;
        end
    end

    // Registered read response; pending_o holds between reads.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_pending_v <= 1'b0;
            r_pending   <= 1'b0;
        end else begin
            r_pending_v <= w_r_fire;
            if (w_r_fire) begin
                r_pending <= (w_r_cnt != '0);
            end
        end
    end

`ifdef BP_CCE_PENDING_CTR_ERR_EN
    logic r_err;

    // Sticky error on saturating an accepted write.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_err <= 1'b0;
        end else if (w_w_fire && (w_ovf || w_unf)) begin
            r_err <= 1'b1;
        end
    end

    assign w_err = r_err;

    // Flag counter misuse and traffic offered while busy.
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(w_w_fire && w_ovf))
                else $error("pending counter overflow");
            assert (!(w_w_fire && w_unf))
                else $error("pending counter underflow");
            assert (!(w_busy && (bus.w_v_i || bus.r_v_i)))
                else $error("pending access while busy");
        end
    end

    assign w_unused = ^{w_w_addr, w_r_addr};
`else
    assign w_err    = 1'b0;
    assign w_unused = ^{w_w_addr, w_r_addr, w_ovf, w_unf};
`endif

    assign bus.pending_v_o = r_pending_v;
    assign bus.pending_o   = r_pending;
    assign bus.busy_o      = w_busy;
    assign bus.err_o       = w_err;
endmodule

// File: tb/tb_bp_cce_pending_ctr.sv
// tb_bp_cce_pending_ctr: directed vectors and reset/clear/saturation sequences.
// Honours BP_CCE_PENDING_CTR_ERR_EN when predicting err_o.
module tb_bp_cce_pending_ctr;
    localparam int PAW = 40;
`ifdef BP_CCE_PENDING_CTR_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    int   checks  = 0;
    int   errors  = 0;

    bp_cce_pending_ctr_if #(.paddr_width_p(PAW)) bus ();

    bp_cce_pending_ctr #(
        .paddr_width_p   (PAW),
        .num_entries_p   (256),
        .cnt_width_p     (4),
        .lg_block_bytes_p(6)
    ) dut (
        .clk_i    (clk),
        .reset_n_i(reset_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           wv;
        logic [PAW-1:0] wa;
        logic           wb;
        logic           inc;
        logic           rv;
        logic [PAW-1:0] ra;
        logic           rb;
        logic           ev;
        logic           ep;
    } vec_t;

    vec_t vt [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wv, input logic [PAW-1:0] wa, input logic wb,
                         input logic inc, input logic rv, input logic [PAW-1:0] ra,
                         input logic rb);
        bus.w_v_i           = wv;
        bus.w_addr_i        = wa;
        bus.w_addr_bypass_i = wb;
        bus.pending_i       = inc;
        bus.r_v_i           = rv;
        bus.r_addr_i        = ra;
        bus.r_addr_bypass_i = rb;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic wait_clear(input string nm);
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (bus.busy_o && n < 400);
        chk(nm, n, 257);
    endtask

    task automatic read_all(input string nm);
        int bad;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            drive(1'b0, '0, 1'b0, 1'b0, 1'b1, PAW'(i), 1'b1);
            cyc();
            if (bus.pending_v_o !== 1'b1 || bus.pending_o !== 1'b0) bad++;
        end
        idle();
        chk(nm, bad, 0);
    endtask

    function automatic vec_t mk(input logic wv, input logic [PAW-1:0] wa, input logic wb,
                                input logic inc, input logic rv, input logic [PAW-1:0] ra,
                                input logic rb, input logic ev, input logic ep);
        vec_t v;
        v.wv = wv; v.wa = wa; v.wb = wb; v.inc = inc;
        v.rv = rv; v.ra = ra; v.rb = rb; v.ev = ev; v.ep = ep;
        return v;
    endfunction

    initial begin
        vt.push_back(mk(1, 40'h1040, 0, 1, 0, 40'h0,    0, 0, 0));
        vt.push_back(mk(1, 40'h1040, 0, 1, 1, 40'h1040, 0, 1, 1));
        vt.push_back(mk(1, 40'h1040, 0, 0, 1, 40'h1040, 0, 1, 1));
        vt.push_back(mk(1, 40'h1040, 0, 0, 1, 40'h1040, 0, 1, 0));
        vt.push_back(mk(0, 40'h0,    0, 0, 1, 40'h1040, 0, 1, 0));
        vt.push_back(mk(1, 40'h41,   1, 1, 1, 40'h1040, 0, 1, 1));
        vt.push_back(mk(0, 40'h0,    0, 0, 1, 40'h40,   1, 1, 0));
        vt.push_back(mk(0, 40'h0,    0, 0, 0, 40'h0,    0, 0, 0));
        vt.push_back(mk(0, 40'h0,    0, 0, 1, 40'h1040, 0, 1, 1));
        vt.push_back(mk(0, 40'h0,    0, 0, 0, 40'h0,    0, 0, 1));
        vt.push_back(mk(1, 40'h41,   1, 0, 1, 40'h41,   1, 1, 0));
        vt.push_back(mk(1, 40'h5,    1, 1, 1, 40'h6,    1, 1, 0));
        vt.push_back(mk(0, 40'h0,    0, 0, 1, 40'h5,    1, 1, 1));
        vt.push_back(mk(1, 40'h5,    1, 0, 1, 40'h1040, 0, 1, 0));
        vt.push_back(mk(0, 40'h0,    0, 0, 1, 40'h5,    1, 1, 0));
        vt.push_back(mk(1, 40'hF000000080, 0, 1, 1, 40'h2, 1, 1, 1));
        vt.push_back(mk(1, 40'h2,    1, 0, 0, 40'h0,    0, 0, 1));
        vt.push_back(mk(0, 40'h0,    0, 0, 1, 40'h2,    1, 1, 0));

        idle();
        #1 reset_n = 1'b0;
        cyc(); cyc(); cyc();
        chk("rst_busy", bus.busy_o, 1);
        chk("rst_pv", bus.pending_v_o, 0);
        chk("rst_p", bus.pending_o, 0);
        chk("rst_err", bus.err_o, 0);

        reset_n = 1'b1;
        wait_clear("clear_len");
        read_all("clear_all_zero");

        foreach (vt[i]) begin
            drive(vt[i].wv, vt[i].wa, vt[i].wb, vt[i].inc,
                  vt[i].rv, vt[i].ra, vt[i].rb);
            cyc();
            chk($sformatf("vec%0d_pv", i), bus.pending_v_o, vt[i].ev);
            chk($sformatf("vec%0d_p", i), bus.pending_o, vt[i].ep);
            chk($sformatf("vec%0d_err", i), bus.err_o, 0);
        end
        idle();

        for (int k = 1; k <= 16; k++) begin
            drive(1, 40'h10, 1, 1, 0, '0, 0);
            cyc();
            if (k == 15) chk("sat_err15", bus.err_o, 0);
        end
        chk("sat_err16", bus.err_o, ERR_EN);
        drive(0, '0, 0, 0, 1, 40'h10, 1);
        cyc();
        chk("sat_rd", bus.pending_o, 1);
        for (int k = 0; k < 14; k++) begin
            drive(1, 40'h10, 1, 0, 0, '0, 0);
            cyc();
        end
        drive(0, '0, 0, 0, 1, 40'h10, 1);
        cyc();
        chk("sat_14dec", bus.pending_o, 1);
        drive(1, 40'h10, 1, 0, 1, 40'h10, 1);
        cyc();
        chk("sat_15dec", bus.pending_o, 0);
        chk("sat_err_hold", bus.err_o, ERR_EN);

        drive(1, 40'h7, 1, 1, 0, '0, 0);
        cyc();
        drive(0, '0, 0, 0, 1, 40'h7, 1);
        cyc();
        chk("pre_rst_pv", bus.pending_v_o, 1);
        chk("pre_rst_p", bus.pending_o, 1);
        idle();
        reset_n = 1'b0;
        #1;
        chk("async_busy", bus.busy_o, 1);
        chk("async_pv", bus.pending_v_o, 0);
        chk("async_p", bus.pending_o, 0);
        chk("async_err", bus.err_o, 0);
        cyc(); cyc();
        reset_n = 1'b1;
        for (int k = 0; k < 101; k++) cyc();
        chk("midclr_busy", bus.busy_o, 1);
        reset_n = 1'b0;
        #1;
        chk("midclr_rst_busy", bus.busy_o, 1);
        chk("midclr_rst_pv", bus.pending_v_o, 0);
        chk("midclr_rst_p", bus.pending_o, 0);
        cyc();
        reset_n = 1'b1;
        wait_clear("reclear_len");
        read_all("reclear_all_zero");

        chk("unf_err0", bus.err_o, 0);
        drive(1, 40'h30, 1, 0, 1, 40'h30, 1);
        cyc();
        chk("unf_rd", bus.pending_o, 0);
        chk("unf_err", bus.err_o, ERR_EN);
        drive(0, '0, 0, 0, 1, 40'h30, 1);
        cyc();
        chk("unf_stay0", bus.pending_o, 0);
        idle();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
